gray_seq_gen: RTL and testbench

//  Upstream stage for the gray4_binary gray-to-binary converter: generates a stream of WIDTH-bit Gray codes.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_seq_gen.sv | 97 +++++++++
 tb/tb_gray_seq_gen.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared state encodings and code helpers for the Gray sequence generator.
// Helpers work on a MAX_W-bit container; callers size-cast to their own WIDTH.
package gray_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Terminal code is all-ones (of width w) when counting up, zero when counting down.
    function automatic logic is_terminal(input logic [MAX_W-1:0] cnt,
                                         input logic             up_dn,
                                         input int unsigned      w);
        logic [MAX_W-1:0] ones;
        ones = '1;
        ones = ones >> (MAX_W - w);
        return up_dn ? (cnt == ones) : (cnt == '0);
    endfunction

endpackage

// File: rtl/gray_seq_gen.sv
// Valid/ready Gray code source: up/down, loadable, wrap or stop-at-terminal,
// with a binary shadow of every code for checking a downstream converter.
module gray_seq_gen
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g_out,
    output logic             g_valid,
    input  logic             g_ready,
    output logic [WIDTH-1:0] bin_shadow,
    output logic             tc,
    output logic             busy
);

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt, cnt_step;
    logic             stop_pend, stop_pend_nxt;
    logic             tc_nxt;
    logic             xfer;
    logic             term;

    assign xfer     = g_valid & g_ready;
    assign term     = is_terminal(MAX_W'(cnt), up_dn, WIDTH);
    assign cnt_step = up_dn ? cnt + WIDTH'(1) : cnt - WIDTH'(1);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stop_pend_nxt = stop_pend;
        tc_nxt        = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                stop_pend_nxt = 1'b0;
                // load beats the DONE restart value when both arrive together
                if (load)
                    cnt_nxt = load_val;
                else if (state == ST_DONE && start)
                    cnt_nxt = up_dn ? '0 : '1;
                if (start)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop)
                    stop_pend_nxt = 1'b1;
                if (xfer) begin
                    tc_nxt = term;
                    if (stop_pend) begin
                        state_nxt     = ST_IDLE;
                        cnt_nxt       = cnt_step;
                        stop_pend_nxt = 1'b0;
                    end else if (term && !WRAP) begin
                        // hold the terminal value so DONE reports where we stopped
                        state_nxt     = ST_DONE;
                        stop_pend_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt_step;
                    end
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                stop_pend_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stop_pend <= 1'b0;
            g_out     <= '0;
            g_valid   <= 1'b0;
            tc        <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stop_pend <= stop_pend_nxt;
            g_out     <= WIDTH'(bin2gray(MAX_W'(cnt_nxt)));
            g_valid   <= (state_nxt == ST_RUN);
            tc        <= tc_nxt;
        end
    end

    assign bin_shadow = cnt;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen: scoreboard of expected codes popped on each transfer,
// plus a Gray-to-binary model standing in for the downstream converter.
module tb_gray_seq_gen;

    typedef struct {
        logic [3:0] code;
        logic [3:0] bin;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WRAP=1 instance
    logic       start, stop, up_dn, load, g_ready;
    logic [3:0] load_val, g_out, bin_shadow;
    logic       g_valid, tc, busy;

    // WRAP=0 instance
    logic       start1, stop1, up_dn1, load1, g_ready1;
    logic [3:0] load_val1, g_out1, bin_shadow1;
    logic       g_valid1, tc1, busy1;

    gray_seq_gen #(.WIDTH(4), .WRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .g_out(g_out), .g_valid(g_valid),
        .g_ready(g_ready), .bin_shadow(bin_shadow), .tc(tc), .busy(busy)
    );

    gray_seq_gen #(.WIDTH(4), .WRAP(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .up_dn(up_dn1),
        .load(load1), .load_val(load_val1), .g_out(g_out1), .g_valid(g_valid1),
        .g_ready(g_ready1), .bin_shadow(bin_shadow1), .tc(tc1), .busy(busy1)
    );

    int   n_asrt = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [3:0] prev_code;
    logic       have_prev = 1'b0;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk_v(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitor: sampled on the falling edge, ahead of the accepting rising edge.
    always @(negedge clk) begin
        if (rst_n && g_valid) begin
            if (g_ready) begin
                n_asrt++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow observed=transfer of %b expected=no transfer", g_out);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_v("g_out", g_out, e.code);
                    chk_v("bin_shadow", bin_shadow, e.bin);
                end
                chk_v("conv", g2b(g_out), bin_shadow);
                if (have_prev)
                    chk_v("onebit", 4'($countones(prev_code ^ g_out)), 4'd1);
                prev_code = g_out;
                have_prev = 1'b1;
            end
        end else begin
            have_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t1_codes [17];
        t1_codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                     4'b0000};

        rst_n = 1'b0;
        start = 0; stop = 0; up_dn = 1; load = 0; load_val = '0; g_ready = 0;
        start1 = 0; stop1 = 0; up_dn1 = 1; load1 = 0; load_val1 = '0; g_ready1 = 0;
        #12;
        chk_v("rst_g_out", g_out, 4'b0000);
        chk_v("rst_bin", bin_shadow, 4'd0);
        chk_b("rst_valid", g_valid, 1'b0);
        chk_b("rst_tc", tc, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Stop-at-terminal, counting down from a loaded value
        up_dn1 = 0; load_val1 = 4'd2; load1 = 1; start1 = 1; g_ready1 = 1;
        step();
        load1 = 0; start1 = 0;
        chk_v("nw_code0", g_out1, 4'b0011);
        chk_v("nw_bin0", bin_shadow1, 4'd2);
        chk_b("nw_valid0", g_valid1, 1'b1);
        step();
        chk_v("nw_code1", g_out1, 4'b0001);
        step();
        chk_v("nw_code2", g_out1, 4'b0000);
        chk_b("nw_tc_pre", tc1, 1'b0);
        step();
        chk_b("nw_done_valid", g_valid1, 1'b0);
        chk_b("nw_done_tc", tc1, 1'b1);
        chk_b("nw_done_busy", busy1, 1'b1);
        chk_v("nw_done_bin", bin_shadow1, 4'd0);
        step();
        chk_b("nw_tc_drop", tc1, 1'b0);
        chk_b("nw_still_busy", busy1, 1'b1);
        g_ready1 = 0; up_dn1 = 0; start1 = 1;
        step();
        start1 = 0;
        chk_v("nw_restart_code", g_out1, 4'b1000);
        chk_v("nw_restart_bin", bin_shadow1, 4'd15);
        chk_b("nw_restart_valid", g_valid1, 1'b1);

        // Full up-count with wrap
        for (int i = 0; i < 17; i++) sb.push_back('{t1_codes[i], 4'(i)});
        up_dn = 1; g_ready = 1; start = 1;
        step();
        start = 0;
        chk_b("run_valid", g_valid, 1'b1);
        chk_b("run_busy", busy, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 1; i++) step();
        g_ready = 0;
        chk_b("tc_wrap", tc, 1'b1);
        chk_v("wrap_code", g_out, 4'b0000);
        step();
        chk_b("tc_one_cycle", tc, 1'b0);

        // Backpressure hold at 0011
        sb.push_back('{4'b0001, 4'd1});
        sb.push_back('{4'b0011, 4'd2});
        sb.push_back('{4'b0010, 4'd3});
        g_ready = 1;
        for (int i = 0; i < 8 && g_out !== 4'b0011; i++) step();
        g_ready = 0;
        chk_v("reach_0011", g_out, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_v("hold_code", g_out, 4'b0011);
            chk_v("hold_bin", bin_shadow, 4'd2);
            chk_b("hold_valid", g_valid, 1'b1);
        end
        g_ready = 1;
        step();
        g_ready = 0;
        chk_v("after_hold", g_out, 4'b0010);

        // stop requested under backpressure at 0110
        sb.push_back('{4'b0110, 4'd4});
        g_ready = 1;
        step();
        g_ready = 0;
        chk_v("at_0110", g_out, 4'b0110);
        stop = 1;
        step();
        stop = 0;
        chk_b("stop_valid_held", g_valid, 1'b1);
        step();
        chk_v("stop_code_held", g_out, 4'b0110);
        g_ready = 1;
        step();
        g_ready = 0;
        chk_b("stop_idle_valid", g_valid, 1'b0);
        chk_b("stop_idle_busy", busy, 1'b0);
        chk_v("stop_cnt", bin_shadow, 4'd5);

        // load ignored in RUN, then honoured with start from IDLE
        sb.push_back('{4'b0111, 4'd5});
        start = 1;
        step();
        start = 0;
        load = 1; load_val = 4'b1010;
        step();
        load = 0;
        chk_v("load_in_run", bin_shadow, 4'd5);
        chk_v("load_in_run_code", g_out, 4'b0111);
        stop = 1;
        step();
        stop = 0;
        g_ready = 1;
        step();
        g_ready = 0;
        chk_b("stop2_valid", g_valid, 1'b0);
        chk_v("stop2_cnt", bin_shadow, 4'd6);

        sb.push_back('{4'b1111, 4'd10});
        sb.push_back('{4'b1110, 4'd11});
        sb.push_back('{4'b1010, 4'd12});
        sb.push_back('{4'b1110, 4'd11});
        load = 1; load_val = 4'b1010; start = 1;
        step();
        load = 0; start = 0;
        chk_v("load_start_code", g_out, 4'b1111);
        chk_v("load_start_bin", bin_shadow, 4'd10);
        g_ready = 1;
        step();
        step();
        g_ready = 0;
        chk_v("before_dir", g_out, 4'b1010);
        up_dn = 0; g_ready = 1;
        step();
        g_ready = 0;
        chk_v("dir_change", g_out, 4'b1110);
        chk_v("dir_bin", bin_shadow, 4'd11);
        chk_v("sb_level", 4'(sb.size()), 4'd1);

        // Asynchronous reset while valid
        #2;
        rst_n = 1'b0;
        #1;
        chk_v("arst_code", g_out, 4'b0000);
        chk_b("arst_valid", g_valid, 1'b0);
        chk_b("arst_busy", busy, 1'b0);
        chk_b("arst_busy_nw", busy1, 1'b0);
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        chk_b("post_rst_valid", g_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
